// File: rtl/i2c_wb_pkg.sv
// i2c_wb_pkg: shared state encoding and constants for the I2C-to-Wishbone bridge.
package i2c_wb_pkg;
    localparam logic [4:0] ST_IDLE = 5'b00001;
    localparam logic [4:0] ST_ADDR = 5'b00010;
    localparam logic [4:0] ST_DATA = 5'b00100;
    localparam logic [4:0] ST_WR   = 5'b01000;
    localparam logic [4:0] ST_RD   = 5'b10000;
    localparam logic [2:0] WBM_CTI_CLASSIC = 3'b111;
    localparam logic [7:0] RD_ERR_BYTE = 8'hFF;
endpackage

// File: rtl/i2c_wb_lane.sv
// i2c_wb_lane: big-endian byte-lane select, write replication and read extraction.
module i2c_wb_lane #(
    parameter int WB_DW = 32
) (
    input  logic [1:0]         lane,
    input  logic [7:0]         wr_byte,
    input  logic [WB_DW-1:0]   rd_word,
    output logic [WB_DW/8-1:0] sel,
    output logic [WB_DW-1:0]   wr_word,
    output logic [7:0]         rd_byte
);
    localparam int NB = WB_DW / 8;
    logic [1:0] idx;
    // Lane 0 sits in the most significant byte of the bus word.
    assign idx = 2'(NB - 1) - (lane & 2'(NB - 1));
    assign sel = NB'(1) << idx;
    assign wr_word = {NB{wr_byte}};
    assign rd_byte = 8'(rd_word >> {idx, 3'b000});
endmodule

// File: rtl/i2c_wb_bridge.sv
// i2c_wb_bridge: I2C slave byte stream to Wishbone B3 classic master.
// Define I2C_WB_TIMEOUT_EN to abort cycles that see no ack/err within TIMEOUT_CYC cycles.
module i2c_wb_bridge
    import i2c_wb_pkg::*;
#(
    parameter int ADR_BYTES     = 1,
    parameter int WB_AW         = 32,
    parameter int WB_DW         = 32,
    parameter int MEM_SIZE_BITS = 8,
    parameter int TIMEOUT_CYC   = 255
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [7:0]         rx_dat_i,
    input  logic               rx_valid_i,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               tx_req_i,
    output logic [7:0]         tx_dat_o,
    output logic               tx_valid_o,
    output logic               busy_o,
    output logic               err_o,
    output logic [WB_AW-1:0]   wbm_adr_o,
    output logic [WB_DW-1:0]   wbm_dat_o,
    output logic [WB_DW/8-1:0] wbm_sel_o,
    output logic               wbm_we_o,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic [2:0]         wbm_cti_o,
    output logic [1:0]         wbm_bte_o,
    input  logic [WB_DW-1:0]   wbm_dat_i,
    input  logic               wbm_ack_i,
    input  logic               wbm_err_i
);
    logic [4:0] state;
    logic [MEM_SIZE_BITS-1:0] ptr, ptr_shift;
    logic [2:0] cnt;
    logic [7:0] wr_byte, pend_byte, nxt_byte, rd_byte;
    logic pend, nxt_pend, start_l, stop_l, cyc, we, bus_err, done, go_idle, go_addr;
    logic [WB_DW/8-1:0] sel;
    logic [WB_DW-1:0] wr_word;

    assign cyc = (state == ST_WR) | (state == ST_RD);
    assign we = state == ST_WR;
    assign done = cyc & (wbm_ack_i | bus_err);
    assign ptr_shift = MEM_SIZE_BITS'({ptr, rx_dat_i});
    assign nxt_pend = pend | rx_valid_i;
    assign nxt_byte = pend ? pend_byte : rx_dat_i;
    assign go_idle = stop_l | stop_i;
    assign go_addr = start_l | start_i;

    i2c_wb_lane #(.WB_DW(WB_DW)) u_lane (
        .lane    (2'(ptr)),
        .wr_byte (wr_byte),
        .rd_word (wbm_dat_i),
        .sel     (sel),
        .wr_word (wr_word),
        .rd_byte (rd_byte)
    );

    assign wbm_adr_o = WB_AW'(ptr);
    assign wbm_dat_o = we ? wr_word : '0;
    assign wbm_sel_o = cyc ? sel : '0;
    assign wbm_we_o  = we;
    assign wbm_cyc_o = cyc;
    assign wbm_stb_o = cyc;
    assign wbm_cti_o = WBM_CTI_CLASSIC;
    assign wbm_bte_o = 2'b00;
    assign busy_o    = cyc | pend;

`ifdef I2C_WB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tcnt;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) tcnt <= '0;
        else tcnt <= (cyc && !done) ? tcnt + 1'b1 : '0;
    end
    assign bus_err = wbm_err_i | (cyc && tcnt == TW'(TIMEOUT_CYC - 1));
`else
    assign bus_err = wbm_err_i;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= ST_IDLE;
            ptr <= '0;
            cnt <= '0;
            wr_byte <= '0;
            pend <= 1'b0;
            pend_byte <= '0;
            start_l <= 1'b0;
            stop_l <= 1'b0;
            err_o <= 1'b0;
            tx_dat_o <= '0;
            tx_valid_o <= 1'b0;
        end else begin
            tx_valid_o <= 1'b0;
            if (cyc) begin
                if (tx_req_i) err_o <= 1'b1;
                if (!done) begin
                    // START/STOP during a bus cycle are held until it completes.
                    start_l <= start_l | start_i;
                    stop_l <= stop_l | stop_i;
                    if (rx_valid_i && pend) err_o <= 1'b1;
                    else if (rx_valid_i) begin
                        pend <= 1'b1;
                        pend_byte <= rx_dat_i;
                    end
                end else begin
                    ptr <= ptr + 1'b1;
                    if (!we) begin
                        tx_dat_o <= bus_err ? RD_ERR_BYTE : rd_byte;
                        tx_valid_o <= 1'b1;
                    end
                    if (nxt_pend) begin
                        state <= ST_WR;
                        wr_byte <= nxt_byte;
                        pend <= pend & rx_valid_i;
                        pend_byte <= rx_dat_i;
                        start_l <= start_l | start_i;
                        stop_l <= stop_l | stop_i;
                    end else begin
                        state <= go_idle ? ST_IDLE : go_addr ? ST_ADDR : ST_DATA;
                        cnt <= '0;
                        start_l <= 1'b0;
                        stop_l <= 1'b0;
                        if (go_addr && !go_idle) err_o <= 1'b0;
                    end
                    if (bus_err) err_o <= 1'b1;
                end
            end else if (stop_i) state <= ST_IDLE;
            else if (start_i) begin
                state <= (rx_valid_i && ADR_BYTES == 1) ? ST_DATA : ST_ADDR;
                cnt <= {2'b00, rx_valid_i};
                err_o <= 1'b0;
                if (rx_valid_i) ptr <= ptr_shift;
            end else if (state == ST_ADDR && rx_valid_i) begin
                ptr <= ptr_shift;
                cnt <= cnt + 1'b1;
                if (cnt == 3'(ADR_BYTES - 1)) state <= ST_DATA;
            end else if (state == ST_DATA && rx_valid_i) begin
                state <= ST_WR;
                wr_byte <= rx_dat_i;
            end else if (state != ST_IDLE && tx_req_i) state <= ST_RD;
        end
    end
endmodule

// File: tb/tb_i2c_wb_bridge.sv
// tb_i2c_wb_bridge: directed self-checking bench for i2c_wb_bridge with default parameters.
module tb_i2c_wb_bridge;
    logic clk_i = 1'b0;
    logic rst_n_i = 1'b0;
    logic [7:0] rx_dat = 8'h00;
    logic rx_valid = 1'b0, start = 1'b0, stop = 1'b0, tx_req = 1'b0;
    logic [7:0] tx_dat;
    logic tx_valid, busy, err;
    logic [31:0] adr, dat_o, dat_i;
    logic [3:0] sel;
    logic we, cyc, stb;
    logic [2:0] cti;
    logic [1:0] bte;
    logic ack = 1'b0, berr = 1'b0;
    int checks = 0, errors = 0;
    int ack_dly = 0, wait_n = 0;
    logic err_next = 1'b0;
    logic [7:0] mem [256];
    logic [31:0] wr_adr [16], wr_dat [16], rd_adr [16];
    logic [3:0] wr_sel [16];
    int wr_n = 0, rd_n = 0, tx_n = 0, cyc_n = 0, ack_cyc = 0, tx_cyc = 0;
    int n, r;
    logic [7:0] base;

    always #5 clk_i = ~clk_i;

    i2c_wb_bridge dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .rx_dat_i(rx_dat), .rx_valid_i(rx_valid),
        .start_i(start), .stop_i(stop), .tx_req_i(tx_req), .tx_dat_o(tx_dat),
        .tx_valid_o(tx_valid), .busy_o(busy), .err_o(err), .wbm_adr_o(adr),
        .wbm_dat_o(dat_o), .wbm_sel_o(sel), .wbm_we_o(we), .wbm_cyc_o(cyc),
        .wbm_stb_o(stb), .wbm_cti_o(cti), .wbm_bte_o(bte), .wbm_dat_i(dat_i),
        .wbm_ack_i(ack), .wbm_err_i(berr)
    );

    // Big-endian memory view: lowest address in the top byte.
    assign base = {adr[7:2], 2'b00};
    assign dat_i = {mem[base], mem[base | 8'd1], mem[base | 8'd2], mem[base | 8'd3]};

    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ack <= 1'b0;
            berr <= 1'b0;
            wait_n <= 0;
        end else begin
            ack <= 1'b0;
            berr <= 1'b0;
            if (cyc && stb && !ack && !berr) begin
                if (wait_n >= ack_dly) begin
                    ack <= !err_next;
                    berr <= err_next;
                    wait_n <= 0;
                end else wait_n <= wait_n + 1;
            end
        end
    end

    always @(posedge clk_i) begin
        cyc_n++;
        if (cyc && we && ack && wr_n < 16) begin
            wr_adr[wr_n] = adr;
            wr_dat[wr_n] = dat_o;
            wr_sel[wr_n] = sel;
            mem[adr[7:0]] = dat_o[7:0];
            wr_n++;
        end
        if (cyc && !we && (ack || berr) && rd_n < 16) begin
            rd_adr[rd_n] = adr;
            rd_n++;
            ack_cyc = cyc_n;
        end
        if (tx_valid) begin
            tx_n++;
            tx_cyc = cyc_n;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic rx(input logic [7:0] d);
        rx_dat = d;
        rx_valid = 1'b1;
        @(negedge clk_i);
        rx_valid = 1'b0;
    endtask

    task automatic st();
        start = 1'b1;
        @(negedge clk_i);
        start = 1'b0;
    endtask

    task automatic txr();
        tx_req = 1'b1;
        @(negedge clk_i);
        tx_req = 1'b0;
    endtask

    task automatic tick(input int k);
        repeat (k) @(negedge clk_i);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && busy; i++) @(negedge clk_i);
        chk("idle", 32'(busy), 32'd0);
    endtask

    task automatic wait_tx(input int n0);
        for (int i = 0; i < 100 && tx_n == n0; i++) @(negedge clk_i);
        chk("tx_seen", 32'(tx_n != n0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h3C;
        #12;
        chk("rst_cyc", 32'(cyc), 32'd0);
        chk("rst_stb", 32'(stb), 32'd0);
        chk("rst_cti", 32'(cti), 32'd7);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_txv", 32'(tx_valid), 32'd0);
        chk("rst_adr", adr, 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        tick(1);

        st(); rx(8'h05); rx(8'hA5);
        wait_idle();
        chk("w1_n", 32'(wr_n), 32'd1);
        chk("w1_adr", wr_adr[0], 32'h5);
        chk("w1_sel", 32'(wr_sel[0]), 32'h4);
        chk("w1_dat", wr_dat[0], 32'hA5A5A5A5);

        n = tx_n; r = rd_n;
        st(); rx(8'h05); st(); txr();
        wait_tx(n);
        chk("r1_adr", rd_adr[r], 32'h5);
        chk("r1_dat", 32'(tx_dat), 32'hA5);
        chk("r1_lat", 32'(tx_cyc - ack_cyc), 32'd1);
        txr();
        wait_tx(n + 1);
        chk("r2_adr", rd_adr[r + 1], 32'h6);
        chk("r2_dat", 32'(tx_dat), 32'h3A);

        st(); rx(8'hFF); rx(8'h11); rx(8'h22);
        wait_idle();
        chk("wrap_n", 32'(wr_n), 32'd3);
        chk("wrap_adr0", wr_adr[1], 32'hFF);
        chk("wrap_sel0", 32'(wr_sel[1]), 32'h1);
        chk("wrap_dat0", wr_dat[1], 32'h11111111);
        chk("wrap_adr1", wr_adr[2], 32'h00);
        chk("wrap_sel1", 32'(wr_sel[2]), 32'h8);
        chk("wrap_dat1", wr_dat[2], 32'h22222222);

        ack_dly = 3;
        st(); rx(8'h40); rx(8'h10); tick(1); rx(8'h20); tick(1); rx(8'h30);
        chk("b2b_busy", 32'(busy), 32'd1);
        wait_idle();
        chk("b2b_n", 32'(wr_n), 32'd5);
        chk("b2b_adr0", wr_adr[3], 32'h40);
        chk("b2b_dat0", wr_dat[3], 32'h10101010);
        chk("b2b_adr1", wr_adr[4], 32'h41);
        chk("b2b_sel1", 32'(wr_sel[4]), 32'h4);
        chk("b2b_dat1", wr_dat[4], 32'h20202020);
        chk("b2b_err", 32'(err), 32'd1);
        st();
        chk("err_clr", 32'(err), 32'd0);

        ack_dly = 0; err_next = 1'b1;
        n = tx_n; r = rd_n;
        rx(8'h80); txr();
        wait_tx(n);
        chk("berr_adr", rd_adr[r], 32'h80);
        chk("berr_dat", 32'(tx_dat), 32'hFF);
        chk("berr_err", 32'(err), 32'd1);
        err_next = 1'b0;
        txr();
        wait_tx(n + 1);
        chk("berr_inc", rd_adr[r + 1], 32'h81);
        chk("berr_nxt", 32'(tx_dat), 32'hBD);

        ack_dly = 20;
        st(); rx(8'h10); rx(8'h55); tick(2);
        chk("mid_cyc", 32'(cyc), 32'd1);
        #2 rst_n_i = 1'b0;
        #1;
        chk("arst_cyc", 32'(cyc), 32'd0);
        chk("arst_stb", 32'(stb), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        ack_dly = 0;
        n = tx_n; r = rd_n;
        txr(); tick(2);
        chk("idle_ign", 32'(rd_n - r), 32'd0);
        st(); txr();
        wait_tx(n);
        chk("ptr0_adr", rd_adr[r], 32'h0);
        chk("ptr0_dat", 32'(tx_dat), 32'h22);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
